// File: rtl/ptx_sr_if.sv
// ptx_sr_if: load/serial bus between a word source and the ptx_sr transmitter.
//   load_valid   : source -> block, a word is on data_in
//   load_ready   : block -> source, a word can be accepted this cycle
//   data_in      : source -> block, parallel word (NUM_BITS wide)
//   shift_enable : tick generator -> block, consume the current bit
//   serial_out   : block -> line driver, idle level 1
//   busy         : block -> source, a word is in flight
//   done         : block -> source, one-cycle pulse after the final bit
// The master modport is the source/tick side; the slave modport is ptx_sr.
interface ptx_sr_if #(
  parameter int NUM_BITS = 4
) ();
  logic                load_valid;
  logic                load_ready;
  logic [NUM_BITS-1:0] data_in;
  logic                shift_enable;
  logic                serial_out;
  logic                busy;
  logic                done;

  modport master (
    output load_valid, data_in, shift_enable,
    input  load_ready, serial_out, busy, done
  );

  modport slave (
    input  load_valid, data_in, shift_enable,
    output load_ready, serial_out, busy, done
  );
endinterface

// File: rtl/ptx_sr.sv
// ptx_sr: parallel-to-serial transmit shift register.
// Accepts a NUM_BITS word over a valid/ready handshake, then sends one bit per
// shift_enable strobe on serial_out, pulsing done for one cycle after the last
// bit has been consumed.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : ptx_sr_if.slave (load_valid/load_ready/data_in/shift_enable/
//         serial_out/busy/done)
// Parameters:
//   NUM_BITS  : word width (>= 2)
//   SHIFT_MSB : 1 = MSB first, 0 = LSB first
// Build option:
//   PTX_SR_PARITY_EN : when defined, an even-parity bit (XOR of the loaded word)
//                      is sent after the data bits.
module ptx_sr #(
  parameter int NUM_BITS  = 4,
  parameter bit SHIFT_MSB = 1'b1
) (
  input logic     clk,
  input logic     rst,
  ptx_sr_if.slave bus
);

`ifdef PTX_SR_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // The parity bit rides in the register behind the data, so it reaches the
  // head naturally after the data bits.
  localparam int                SR_W  = NUM_BITS + PAR_W;
  localparam int                CNT_W = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_BITS - 1 + PAR_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic              load_take;
  logic              shift_take;
  logic              terminal;
  logic              head;

  function automatic logic [SR_W-1:0] load_word(input logic [NUM_BITS-1:0] d);
`ifdef PTX_SR_PARITY_EN
    if (SHIFT_MSB) return {d, ^d};
    else           return {^d, d};
`else
    return d;
`endif
  endfunction

  // Move toward the head by one and backfill the vacated end with idle ones.
  function automatic logic [SR_W-1:0] shift_word(input logic [SR_W-1:0] s);
    if (SHIFT_MSB) return {s[SR_W-2:0], 1'b1};
    else           return {1'b1, s[SR_W-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_take  = 1'b0;
    shift_take = 1'b0;
    terminal   = 1'b0;
    case (state_q)
      IDLE: begin
        // A strobe coinciding with a load is dropped; the first bit gets a
        // full strobe period on the line.
        if (bus.load_valid) begin
          load_take = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_enable) begin
          shift_take = 1'b1;
          if (cnt_q == LAST) begin
            terminal = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '1;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= terminal;
      if (load_take) begin
        sr_q  <= load_word(bus.data_in);
        cnt_q <= '0;
      end else if (shift_take) begin
        sr_q  <= shift_word(sr_q);
        // Holding at LAST on the final strobe keeps the counter from wrapping
        // when the parity bit pushes the count past the counter's range.
        if (!terminal) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign head           = SHIFT_MSB ? sr_q[SR_W-1] : sr_q[0];
  assign bus.serial_out = (state_q == SHIFT) ? head : 1'b1;
  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_ptx_sr.sv
// tb_ptx_sr: directed bench for ptx_sr with one MSB-first and one LSB-first
// instance (NUM_BITS=4). Inputs are driven and outputs sampled 1 time unit
// after each rising edge.
module tb_ptx_sr;

`ifdef PTX_SR_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  ptx_sr_if #(.NUM_BITS(4)) m_if ();
  ptx_sr_if #(.NUM_BITS(4)) l_if ();

  ptx_sr #(.NUM_BITS(4), .SHIFT_MSB(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(m_if));
  ptx_sr #(.NUM_BITS(4), .SHIFT_MSB(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(l_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs an already-loaded word through u_msb; returns in the done cycle.
  task automatic msb_word(input logic [3:0] d, input int gap, input bit poke, input string tag);
    logic eb;
    for (int i = 0; i < 4 + PAR; i++) begin
      eb = (i < 4) ? d[3-i] : ^d;
      chk({tag, "_bit"}, 32'(m_if.serial_out), 32'(eb));
      chk({tag, "_busy"}, 32'(m_if.busy), 32'd1);
      chk({tag, "_rdy"}, 32'(m_if.load_ready), 32'd0);
      for (int g = 0; g < gap; g++) begin
        m_if.shift_enable = 1'b0;
        if (poke) begin
          m_if.load_valid = 1'b1;
          m_if.data_in    = 4'b0101;
        end
        tick();
        chk({tag, "_hold"}, 32'(m_if.serial_out), 32'(eb));
      end
      m_if.shift_enable = 1'b1;
      tick();
      m_if.shift_enable = 1'b0;
      m_if.load_valid   = 1'b0;
    end
    chk({tag, "_done"}, 32'(m_if.done), 32'd1);
    chk({tag, "_idle"}, 32'(m_if.serial_out), 32'd1);
    chk({tag, "_nbusy"}, 32'(m_if.busy), 32'd0);
    chk({tag, "_rdy1"}, 32'(m_if.load_ready), 32'd1);
  endtask

  task automatic lsb_word(input logic [3:0] d, input int gap, input string tag);
    logic eb;
    for (int i = 0; i < 4 + PAR; i++) begin
      eb = (i < 4) ? d[i] : ^d;
      chk({tag, "_bit"}, 32'(l_if.serial_out), 32'(eb));
      chk({tag, "_rdy"}, 32'(l_if.load_ready), 32'd0);
      for (int g = 0; g < gap; g++) begin
        l_if.shift_enable = 1'b0;
        tick();
        chk({tag, "_hold"}, 32'(l_if.serial_out), 32'(eb));
        chk({tag, "_rdyh"}, 32'(l_if.load_ready), 32'd0);
      end
      l_if.shift_enable = 1'b1;
      tick();
      l_if.shift_enable = 1'b0;
    end
    chk({tag, "_done"}, 32'(l_if.done), 32'd1);
    chk({tag, "_idle"}, 32'(l_if.serial_out), 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    m_if.load_valid = 1'b0; m_if.data_in = '0; m_if.shift_enable = 1'b0;
    l_if.load_valid = 1'b0; l_if.data_in = '0; l_if.shift_enable = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ser",  32'(m_if.serial_out), 32'd1);
    chk("rst_rdy",  32'(m_if.load_ready), 32'd1);
    chk("rst_busy", 32'(m_if.busy),       32'd0);
    chk("rst_done", 32'(m_if.done),       32'd0);
    chk("rst_lser", 32'(l_if.serial_out), 32'd1);
    chk("rst_lrdy", 32'(l_if.load_ready), 32'd1);
    rst = 1'b0;
    tick();

    // MSB first, 1010, back-to-back strobes
    m_if.load_valid = 1'b1; m_if.data_in = 4'b1010;
    tick();
    m_if.load_valid = 1'b0;
    chk("t1_b0", 32'(m_if.serial_out), 32'd1);
    chk("t1_busy0", 32'(m_if.busy), 32'd1);
    m_if.shift_enable = 1'b1;
    tick();
    chk("t1_b1", 32'(m_if.serial_out), 32'd0);
    tick();
    chk("t1_b2", 32'(m_if.serial_out), 32'd1);
    tick();
    chk("t1_b3", 32'(m_if.serial_out), 32'd0);
    chk("t1_busy3", 32'(m_if.busy), 32'd1);
    tick();
`ifdef PTX_SR_PARITY_EN
    chk("t1_par", 32'(m_if.serial_out), 32'd0);
    chk("t1_pdone", 32'(m_if.done), 32'd0);
    tick();
`endif
    m_if.shift_enable = 1'b0;
    chk("t1_done", 32'(m_if.done), 32'd1);
    chk("t1_idle", 32'(m_if.serial_out), 32'd1);
    chk("t1_nbusy", 32'(m_if.busy), 32'd0);
    tick();
    chk("t1_done0", 32'(m_if.done), 32'd0);

    // LSB first, 0011, strobe every 3rd cycle
    l_if.load_valid = 1'b1; l_if.data_in = 4'b0011;
    tick();
    l_if.load_valid = 1'b0;
    lsb_word(4'b0011, 2, "t2");
    tick();
    chk("t2_done0", 32'(l_if.done), 32'd0);

    // Load during SHIFT ignored, then load accepted in the done cycle
    m_if.load_valid = 1'b1; m_if.data_in = 4'b1100;
    tick();
    m_if.load_valid = 1'b0;
    msb_word(4'b1100, 1, 1'b1, "t3a");
    m_if.load_valid = 1'b1; m_if.data_in = 4'b0101;
    tick();
    m_if.load_valid = 1'b0;
    chk("t3_done0", 32'(m_if.done), 32'd0);
    msb_word(4'b0101, 0, 1'b0, "t3b");
    tick();

    // Reset mid-word
    m_if.load_valid = 1'b1; m_if.data_in = 4'b0000;
    tick();
    m_if.load_valid = 1'b0;
    m_if.shift_enable = 1'b1;
    tick();
    tick();
    m_if.shift_enable = 1'b0;
    chk("t4_mid", 32'(m_if.serial_out), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_ser",  32'(m_if.serial_out), 32'd1);
    chk("t4_busy", 32'(m_if.busy),       32'd0);
    chk("t4_rdy",  32'(m_if.load_ready), 32'd1);
    chk("t4_done", 32'(m_if.done),       32'd0);
    tick();
    chk("t4_done1", 32'(m_if.done), 32'd0);

    // IDLE ignores strobes
    for (int i = 0; i < 4; i++) begin
      m_if.shift_enable = i[0];
      tick();
      chk("t5_ser",  32'(m_if.serial_out), 32'd1);
      chk("t5_done", 32'(m_if.done),       32'd0);
    end
    // Load and strobe together: strobe dropped
    m_if.load_valid = 1'b1; m_if.data_in = 4'b1001; m_if.shift_enable = 1'b1;
    tick();
    m_if.load_valid = 1'b0; m_if.shift_enable = 1'b0;
    chk("t5_b0", 32'(m_if.serial_out), 32'd1);
    tick();
    chk("t5_b0h", 32'(m_if.serial_out), 32'd1);
    msb_word(4'b1001, 0, 1'b0, "t5");
    tick();

    // 1011: data 1,0,1,1 (+ parity 1 when enabled)
    m_if.load_valid = 1'b1; m_if.data_in = 4'b1011;
    tick();
    m_if.load_valid = 1'b0;
    m_if.shift_enable = 1'b1;
    chk("t6_b0", 32'(m_if.serial_out), 32'd1);
    tick();
    chk("t6_b1", 32'(m_if.serial_out), 32'd0);
    tick();
    chk("t6_b2", 32'(m_if.serial_out), 32'd1);
    tick();
    chk("t6_b3", 32'(m_if.serial_out), 32'd1);
    tick();
`ifdef PTX_SR_PARITY_EN
    chk("t6_par", 32'(m_if.serial_out), 32'd1);
    chk("t6_pbusy", 32'(m_if.busy), 32'd1);
    tick();
`endif
    m_if.shift_enable = 1'b0;
    chk("t6_done", 32'(m_if.done), 32'd1);
    chk("t6_idle", 32'(m_if.serial_out), 32'd1);
    tick();
    chk("t6_done0", 32'(m_if.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
